// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues reads to a synchronous instruction ROM,
// absorbs its one-cycle latency in a small queue and hands {pc, instr}
// pairs to decode over a valid/ready handshake. Redirects flush everything.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready
);

  // Pointer width indexes the queue; count needs one extra bit to hold DEPTH.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [31:0]   pc_reg;
  logic          infl_reg;
  logic [31:0]   infl_pc_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [31:0]   mem_pc_reg    [DEPTH];
  logic [31:0]   mem_instr_reg [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_target;

  // Handshake, queue occupancy projection and ROM request selection.
  always_comb begin
    redirect_target = {redirect_pc[31:2], 2'b00};
    fetch_valid     = (count_reg != '0);
    pop             = fetch_valid & fetch_ready & ~redirect_valid;
    push            = infl_reg & ~redirect_valid;
    // Entries the queue will hold once everything already requested lands.
    occupancy       = {1'b0, count_reg} + {{CW{1'b0}}, infl_reg}
                      - {{CW{1'b0}}, fetch_valid & fetch_ready};
    issue           = (occupancy < DEPTH_V);
    imem_en         = 1'b0;
    imem_addr       = pc_reg;
    if (redirect_valid) begin
      imem_en   = rst_n;
      imem_addr = redirect_target;
    end else begin
      imem_en   = rst_n & issue;
    end
    fetch_pc    = fetch_valid ? mem_pc_reg[rd_ptr_reg]    : 32'h0;
    fetch_instr = fetch_valid ? mem_instr_reg[rd_ptr_reg] : 32'h0;
  end

  // PC, in-flight tracking, queue pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      infl_reg    <= 1'b0;
      infl_pc_reg <= 32'h0;
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
    end else if (redirect_valid) begin
      pc_reg      <= redirect_target + 32'd4;
      infl_reg    <= 1'b1;
      infl_pc_reg <= redirect_target;
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
    end else begin
      if (issue) begin
        pc_reg      <= pc_reg + 32'd4;
        infl_reg    <= 1'b1;
        infl_pc_reg <= pc_reg;
      end else begin
        infl_reg    <= 1'b0;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // One storage slot per queue entry; the ROM response lands at the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_pc_reg[gi]    <= 32'h0;
          mem_instr_reg[gi] <= 32'h0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          mem_pc_reg[gi]    <= infl_pc_reg;
          mem_instr_reg[gi] <= imem_dout;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM model, directed scenarios and a
// randomized phase, with a scoreboard fed by an ideal fetch-stream model.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;

  int vectors;
  int miscompares;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: program words at 0..16, a distinguishable pattern elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h00a22e23;
      32'd4:   return 32'h01c22583;
      32'd8:   return 32'h00a580b3;
      32'd12:  return 32'h0040a103;
      32'd16:  return 32'h0020a423;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) if (imem_en) imem_dout <= rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the ideal stream is consecutive words from the last start
  // address (reset PC or aligned redirect target), each paired with its ROM word.
  logic [63:0] exp_q[$];
  logic [31:0] gen_pc;
  int          stall;

  initial begin
    logic [63:0] e;
    gen_pc = 32'h0;
    stall  = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        exp_q.delete();
        gen_pc = 32'h0;
        stall  = 0;
      end else if (redirect_valid) begin
        chk("redirect_en", {31'b0, imem_en}, 32'd1);
        chk("redirect_addr", imem_addr, {redirect_pc[31:2], 2'b00});
        exp_q.delete();
        gen_pc = {redirect_pc[31:2], 2'b00};
        stall  = 0;
      end else begin
        while (exp_q.size() < 4) begin
          exp_q.push_back({gen_pc, rom(gen_pc)});
          gen_pc = gen_pc + 32'd4;
        end
        if (fetch_valid) stall = 0;
        else stall++;
        chk("stall_bound", {31'b0, (stall >= 3)}, 32'd0);
        if (fetch_valid && fetch_ready) begin
          e = exp_q.pop_front();
          chk("out_pc", fetch_pc, e[63:32]);
          chk("out_instr", fetch_instr, e[31:0]);
        end
      end
    end
  end

  // One cycle of stimulus, driven on the falling edge; returns just before the rising edge.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    fetch_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #4;
  endtask

  task automatic hold_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; fetch_ready = rdy; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #4;
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_en", {31'b0, imem_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
  endtask

  initial begin
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_instr", fetch_instr, 32'h0);

    // Reset release with decode always ready.
    hold_reset(1'b1);
    chk("c0_en", {31'b0, imem_en}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", {31'b0, fetch_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c1_valid", {31'b0, fetch_valid}, 32'd0);
    chk("c1_addr", imem_addr, 32'd4);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("stream_valid", {31'b0, fetch_valid}, 32'd1);
      chk("stream_pc", fetch_pc, 32'(i * 4));
    end

    // Backpressure from reset: queue fills and the ROM goes idle.
    hold_reset(1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'b0, fetch_valid}, 32'd1);
      chk("bp_en", {31'b0, imem_en}, 32'd0);
      chk("bp_pc", fetch_pc, 32'h0);
      chk("bp_instr", fetch_instr, 32'h00a22e23);
      cyc(1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("bp_resume_valid", {31'b0, fetch_valid}, 32'd1);
    end

    // Redirect to 12 with a full queue.
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'd12);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rd12_gap", {31'b0, fetch_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rd12_valid", {31'b0, fetch_valid}, 32'd1);
    chk("rd12_pc", fetch_pc, 32'd12);
    chk("rd12_instr", fetch_instr, 32'h0040a103);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);

    // Redirect coincident with a pop, misaligned target.
    cyc(1'b1, 1'b1, 32'h11);
    chk("rdpop_valid", {31'b0, fetch_valid}, 32'd1);
    chk("rdpop_addr", imem_addr, 32'h10);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rdpop_gap", {31'b0, fetch_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rdpop_pc", fetch_pc, 32'd16);
    chk("rdpop_instr", fetch_instr, 32'h0020a423);

    // Address wrap-around.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_pc0", fetch_pc, 32'hFFFF_FFFC);
    chk("wrap_instr0", fetch_instr, rom(32'hFFFF_FFFC));
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_pc1", fetch_pc, 32'h0);
    chk("wrap_instr1", fetch_instr, 32'h00a22e23);

    // Asynchronous reset pulse mid-stream, away from any clock edge.
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, fetch_valid}, 32'd0);
    chk("async_en", {31'b0, imem_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("restart_valid", {31'b0, fetch_valid}, 32'd1);
    chk("restart_pc", fetch_pc, 32'h0);
    chk("restart_instr", fetch_instr, 32'h00a22e23);

    // Randomized traffic: random backpressure and occasional redirects.
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       tgt = $urandom_range(0, 31);
        1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: tgt = $urandom;
      endcase
      cyc(rdy, rv, tgt);
    end
    repeat (4) cyc(1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
